rr_lock_arbiter: RTL and testbench

- Clocked N-way arbiter with registered one-hot grant, held (locked) until the owner signals done or drops its request.
- Selectable fixed-priority or round-robin policy; sits in front of shared resources (bus master port, shared RAM, DMA engine) in common_cells.
- Successor to the combinational fixed-priority arbiter. Adds a grant lock, a rotating priority pointer, back-to-back handover and an encoded index output.

---
 rtl/rr_lock_arbiter_pkg.sv | 26 ++
 rtl/rr_mask_pick.sv | 63 ++++++
 rtl/rr_lock_arbiter.sv | 115 +++++++++++
 tb/tb_rr_lock_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_lock_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter_pkg
// Brief    : Shared state encoding and sizing helper for the lock arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package rr_lock_arbiter_pkg;

  // The arbiter state is equivalent to "a grant is outstanding".
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so a 2-way arbiter still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage : rr_lock_arbiter_pkg
`default_nettype wire

// File: rtl/rr_mask_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_mask_pick
// Brief    : Combinational rotating-priority picker. Excludes one requester,
//            searches upward from 'start_i' with wrap, returns one-hot + index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mask_pick
  import rr_lock_arbiter_pkg::*;
#(
  parameter int unsigned NUM   = 16,
  parameter int unsigned IDX_W = clog2(NUM)
) (
  input  logic [NUM-1:0]   req_i,
  input  logic [NUM-1:0]   mask_out_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [NUM-1:0]   pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [NUM-1:0]   elig_w;
  logic [2*NUM-1:0] rot_dbl_w;
  logic [NUM-1:0]   rot_w;
  logic [NUM-1:0]   rot_pick_w;
  logic [IDX_W-1:0] rot_idx_w;
  logic [2*NUM-1:0] unrot_dbl_w;
  logic [IDX_W:0]   idx_sum_w;

  assign elig_w = req_i & ~mask_out_i;

  // Rotate so that requester 'start_i' lands at bit 0 (double-width trick
  // gives the wrap for free).
  assign rot_dbl_w = {elig_w, elig_w} >> start_i;
  assign rot_w     = rot_dbl_w[NUM-1:0];

  // Fixed-priority pick on the rotated vector: lowest set bit wins.
  always_comb begin
    rot_pick_w = '0;
    rot_idx_w  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (rot_w[i]) begin
        rot_pick_w    = '0;
        rot_pick_w[i] = 1'b1;
        rot_idx_w     = IDX_W'(i);
      end
    end
  end

  // Undo the rotation: upper half of the left-shifted double vector.
  assign unrot_dbl_w = {rot_pick_w, rot_pick_w} << start_i;
  assign pick_o      = unrot_dbl_w[2*NUM-1:NUM];

  // Index = (rotated index + start) mod NUM; both terms are < NUM.
  assign idx_sum_w = {1'b0, rot_idx_w} + {1'b0, start_i};
  assign idx_o     = (idx_sum_w >= (IDX_W+1)'(NUM))
                   ? IDX_W'(idx_sum_w - (IDX_W+1)'(NUM))
                   : idx_sum_w[IDX_W-1:0];

  assign any_o = |elig_w;

endmodule : rr_mask_pick
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_lock_arbiter
// Brief    : N-way arbiter with registered, locked one-hot grant. Round-robin
//            or fixed priority, with back-to-back handover on release.
// Revision : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int unsigned NUM   = 16,
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned IDX_W = clog2(NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM-1:0]   req,
  input  logic             done,
  output logic [NUM-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM-1:0]   grant_q, grant_d;

  logic [IDX_W-1:0] ptr_nxt_w;
  logic [IDX_W-1:0] start_w;
  logic [NUM-1:0]   mask_w;
  logic             release_w;
  logic [NUM-1:0]   pick_w;
  logic [IDX_W-1:0] pick_idx_w;
  logic             pick_any_w;

  // Pointer value that takes effect on a release: one past the owner, wrapping.
  assign ptr_nxt_w = (idx_q == IDX_W'(NUM - 1)) ? '0 : idx_q + 1'b1;

  // done and a dropped request in the same cycle are one release.
  assign release_w = (state_q == ST_LOCKED) && (done || !req[idx_q]);

  // The releasing owner is excluded from its own handover; while idle there
  // is nobody to exclude. The search starts at the post-release pointer so the
  // handover already honours the rotated priority.
  assign mask_w  = (state_q == ST_LOCKED) ? grant_q : '0;
  assign start_w = !RR_EN ? '0 : ((state_q == ST_LOCKED) ? ptr_nxt_w : ptr_q);

  rr_mask_pick #(
    .NUM   (NUM),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (req),
    .mask_out_i (mask_w),
    .start_i    (start_w),
    .pick_o     (pick_w),
    .idx_o      (pick_idx_w),
    .any_o      (pick_any_w)
  );

  // Next-state: grab on any request when idle, hold while locked, hand over
  // or fall idle on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_w) begin
          grant_d = pick_w;
          idx_d   = pick_idx_w;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (release_w) begin
          ptr_d = ptr_nxt_w;
          if (pick_any_w) begin
            grant_d = pick_w;
            idx_d   = pick_idx_w;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset clears the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = (state_q == ST_LOCKED);

endmodule : rr_lock_arbiter
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_lock_arbiter
// Brief    : Self-checking bench; a round-robin and a fixed-priority instance
//            (NUM=4) share stimulus and are compared to an integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;

  logic [N-1:0] g_rr, g_fx;
  logic [1:0]   i_rr, i_fx;
  logic         v_rr, v_fx;

  int n_checks;
  int n_errors;

  // Model state per instance: [0]=round-robin, [1]=fixed. owner<0 is idle.
  int m_owner [2];
  int m_ptr   [2];
  int m_idx   [2];

  rr_lock_arbiter #(.NUM(N), .RR_EN(1'b1)) u_dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (g_rr),
    .grant_idx (i_rr),
    .grant_vld (v_rr)
  );

  rr_lock_arbiter #(.NUM(N), .RR_EN(1'b0)) u_dut_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (g_fx),
    .grant_idx (i_fx),
    .grant_vld (v_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First requester found scanning start, start+1, ... mod N, skipping excl.
  function automatic int search(input int start, input int excl, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_ptr[m]   = 0;
      m_idx[m]   = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input logic [N-1:0] r, input logic d);
    for (int m = 0; m < 2; m++) begin
      int w;
      int base;
      if (m_owner[m] < 0) begin
        base = (m == 0) ? m_ptr[m] : 0;
        w = search(base, -1, r);
        if (w >= 0) begin
          m_owner[m] = w;
          m_idx[m]   = w;
        end
      end else if (d || !r[m_owner[m]]) begin
        m_ptr[m] = (m_owner[m] + 1) % N;
        base = (m == 0) ? m_ptr[m] : 0;
        w = search(base, m_owner[m], r);
        m_owner[m] = w;
        if (w >= 0) m_idx[m] = w;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg [2];
    for (int m = 0; m < 2; m++) begin
      eg[m] = (m_owner[m] < 0) ? '0 : N'(1 << m_owner[m]);
    end
    chk({tag, "/rr.grant"}, 64'(g_rr), 64'(eg[0]));
    chk({tag, "/rr.idx"},   64'(i_rr), 64'(m_idx[0]));
    chk({tag, "/rr.vld"},   64'(v_rr), 64'(m_owner[0] >= 0));
    chk({tag, "/fx.grant"}, 64'(g_fx), 64'(eg[1]));
    chk({tag, "/fx.idx"},   64'(i_fx), 64'(m_idx[1]));
    chk({tag, "/fx.vld"},   64'(v_fx), 64'(m_owner[1] >= 0));
  endtask

  // One clock: model sees the inputs at the edge, outputs are sampled 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(req, done);
    #1;
    check_model(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    #2;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rot_exp [4];
  logic [N-1:0] fx_exp  [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = 4'b1111;
    done     = 1'b0;
    model_reset();

    // Reset with every request active: nothing granted.
    #12;
    check_model("reset");
    chk("reset.grant_const", 64'(g_rr), 64'd0);
    rst_n = 1'b1;

    // First edge after release grants requester 0.
    step("first");
    chk("first.grant_const", 64'(g_rr), 64'b0001);

    // Hand over to owner 1, then hold it while req[3:2] toggles.
    done = 1'b1;
    step("to1");
    done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = {2'($urandom), 2'b11};
      step("hold");
      chk("hold.rr_const", 64'(g_rr), 64'b0010);
      chk("hold.fx_const", 64'(g_fx), 64'b0010);
    end

    // Round-robin rotation with wrap and no idle gaps.
    rot_exp[0] = 4'b0100; rot_exp[1] = 4'b1000;
    rot_exp[2] = 4'b0001; rot_exp[3] = 4'b0010;
    req  = 4'b1111;
    done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step("rot");
      chk("rot.seq", 64'(g_rr), 64'(rot_exp[c]));
      chk("rot.vld", 64'(v_rr), 64'd1);
    end

    // Fixed priority alternation between requesters 1 and 3.
    fx_exp[0] = 4'b1000; fx_exp[1] = 4'b0010; fx_exp[2] = 4'b1000;
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      step("fixed");
      chk("fixed.seq", 64'(g_fx), 64'(fx_exp[c]));
    end

    // Release by dropping the request with nobody waiting, then wrap from ptr=3.
    done = 1'b0;
    req  = 4'b0000;
    step("drain");
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    req = 4'b0100;
    step("own2");
    chk("own2.grant_const", 64'(g_rr), 64'b0100);
    req = 4'b0000;
    step("drop");
    chk("drop.grant_const", 64'(g_rr), 64'd0);
    chk("drop.vld_const",   64'(v_rr), 64'd0);
    chk("drop.idx_hold",    64'(i_rr), 64'd2);
    req = 4'b0101;
    step("wrap");
    chk("wrap.grant_const", 64'(g_rr), 64'b0001);

    // Move to owner 2 and reset mid-lock; pointer must return to 0.
    req = 4'b0100;
    step("to2");
    chk("to2.grant_const", 64'(g_rr), 64'b0100);
    mid_reset("async");
    chk("async.grant_const", 64'(g_rr), 64'd0);
    req = 4'b1111;
    step("after_rst");
    chk("after_rst.grant_const", 64'(g_rr), 64'b0001);

    // Randomized traffic: requests mostly held, occasional done and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rr_lock_arbiter
`default_nettype wire
